// File: rtl/temp_rx_pkg.sv
// Shared definitions for the temperature-count serial receiver:
// FSM state encoding and default parameter values.
package temp_rx_pkg;

    typedef enum logic [1:0] {
        GAP  = 2'd0,
        IDLE = 2'd1,
        MARK = 2'd2,
        DATA = 2'd3
    } rx_state_t;

    localparam int DEF_DATA_W      = 20;
    localparam int DEF_MARK_CYCLES = 2;
    localparam int DEF_MIN_GAP     = 64;
    localparam int DEF_AVG_LOG2    = 2;

endpackage

// File: rtl/temp_rx_avg.sv
// Frame averager for temp_count_rx (built only when TEMP_RX_AVG_EN is defined).
// Sums 2^AVG_LOG2 completed frames and emits the truncated mean as a
// one-cycle strobe on the frame that completes the set.
module temp_rx_avg
    import temp_rx_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int AVG_LOG2 = DEF_AVG_LOG2
)(
    input  logic              ref_clk,
    input  logic              reset_12,
    input  logic              frame_stb,
    input  logic [DATA_W-1:0] frame_data,
    output logic              result_stb,
    output logic [DATA_W-1:0] result
);

    localparam int ACC_W = DATA_W + AVG_LOG2;

    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    sum;
    logic [AVG_LOG2-1:0] tally;

    // The result includes the frame arriving now, so it costs no extra latency.
    assign sum        = acc + ACC_W'(frame_data);
    assign result_stb = frame_stb && (tally == '1);
    assign result     = sum[ACC_W-1:AVG_LOG2];

    // Accumulate each frame; clear the sum when the last frame of a set lands.
    always_ff @(posedge ref_clk) begin
        if (reset_12) begin
            acc   <= '0;
            tally <= '0;
        end else if (frame_stb) begin
            tally <= tally + 1'b1;
            acc   <= (tally == '1) ? '0 : sum;
        end
    end

endmodule

// File: rtl/temp_count_rx.sv
// Receive-side deserializer for the temperature-sensor counter stream.
// Waits for MIN_GAP idle zeros, locks on a MARK_CYCLES-long run of ones,
// captures DATA_W bits LSB-first and offers the count on valid/ready.
// Optional feature macro: TEMP_RX_AVG_EN (average 2^AVG_LOG2 frames per result).
// MARK_CYCLES is expected to be at least 2 (IDLE consumes the first marker 1).
module temp_count_rx
    import temp_rx_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int MARK_CYCLES = DEF_MARK_CYCLES,
    parameter int MIN_GAP     = DEF_MIN_GAP,
    parameter int AVG_LOG2    = DEF_AVG_LOG2
)(
    input  logic              ref_clk,
    input  logic              reset_12,
    input  logic              sr_in,
    output logic [DATA_W-1:0] count_out,
    output logic              count_valid,
    input  logic              count_ready,
    output logic              overrun,
    output logic              frame_err
);

    localparam int BIT_W  = $clog2(DATA_W);
    localparam int GAP_W  = $clog2(MIN_GAP + 1);
    localparam int MARK_W = $clog2(MARK_CYCLES + 1);

    rx_state_t         state, state_nxt;
    logic [GAP_W-1:0]  gap_cnt, gap_nxt;
    logic [MARK_W-1:0] mark_cnt, mark_nxt;
    logic [BIT_W-1:0]  bit_idx, bit_nxt;
    logic [DATA_W-1:0] shreg;
    logic              data_wr;
    logic              done_nxt;
    logic              frame_done;
    logic              mark_err;
    logic              res_stb;
    logic [DATA_W-1:0] res_data;

    // Next-state and counter updates for the frame-lock FSM.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_nxt = state;
        gap_nxt   = gap_cnt;
        mark_nxt  = mark_cnt;
        bit_nxt   = bit_idx;
        data_wr   = 1'b0;
        done_nxt  = 1'b0;
        mark_err  = 1'b0;
        case (state)
            GAP: begin
                if (sr_in) begin
                    gap_nxt = '0;
                end else if (gap_cnt != GAP_W'(MIN_GAP)) begin
                    gap_nxt = gap_cnt + 1'b1;
                end
                // Looking at the updated count lets a marker start on the very
                // next sample after the MIN_GAP-th zero.
                if (gap_nxt == GAP_W'(MIN_GAP)) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (sr_in) begin
                    mark_nxt  = MARK_W'(1);
                    state_nxt = MARK;
                end
            end
            MARK: begin
                if (sr_in) begin
                    mark_nxt = mark_cnt + 1'b1;
                    if (mark_nxt == MARK_W'(MARK_CYCLES)) begin
                        bit_nxt   = '0;
                        state_nxt = DATA;
                    end
                end else begin
                    // A short marker counts its terminating 0 toward the next gap.
                    mark_err  = 1'b1;
                    gap_nxt   = GAP_W'(1);
                    state_nxt = GAP;
                end
            end
            DATA: begin
                data_wr = 1'b1;
                if (bit_idx == BIT_W'(DATA_W - 1)) begin
                    gap_nxt   = '0;
                    done_nxt  = 1'b1;
                    state_nxt = GAP;
                end else begin
                    bit_nxt = bit_idx + 1'b1;
                end
            end
            default: state_nxt = GAP;
        endcase
    end

    // FSM state, counters and the registered frame-done / frame-error pulses.
    always_ff @(posedge ref_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset_12) begin
            state      <= GAP;
            gap_cnt    <= '0;
            mark_cnt   <= '0;
            bit_idx    <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            gap_cnt    <= gap_nxt;
            mark_cnt   <= mark_nxt;
            bit_idx    <= bit_nxt;
            frame_done <= done_nxt;
            frame_err  <= mark_err;
        end
    end

    // Capture each data sample into its bit position (first sample is the LSB).
    always_ff @(posedge ref_clk) begin
        // NOTE: the shift register is reset even though every bit is rewritten per frame, so a reset leaves no stale count behind.
        if (reset_12) begin
            shreg <= '0;
        end else if (data_wr) begin
            shreg[bit_idx] <= sr_in;
        end
    end

`ifdef TEMP_RX_AVG_EN
    temp_rx_avg #(
        .DATA_W   (DATA_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .ref_clk    (ref_clk),
        .reset_12   (reset_12),
        .frame_stb  (frame_done),
        .frame_data (shreg),
        .result_stb (res_stb),
        .result     (res_data)
    );
`else
    localparam int unused_avg_log2 = AVG_LOG2;

    assign res_stb  = frame_done;
    assign res_data = shreg;
`endif

    // Result handshake: load when free or being consumed, else flag a sticky overrun.
    always_ff @(posedge ref_clk) begin
        if (reset_12) begin
            count_out   <= '0;
            count_valid <= 1'b0;
            overrun     <= 1'b0;
        end else if (res_stb) begin
            if (!count_valid || count_ready) begin
                count_out   <= res_data;
                count_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (count_valid && count_ready) begin
            count_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_temp_count_rx.sv
// Directed self-checking bench for temp_count_rx. Expected counts are pushed
// to a scoreboard queue as frames are driven and popped when the result is due.
// Build with +define+TEMP_RX_AVG_EN to run the averaging scenario instead.
module tb_temp_count_rx;

    localparam int DATA_W = 20;

    logic              ref_clk;
    logic              reset_12;
    logic              sr_in;
    logic [DATA_W-1:0] count_out;
    logic              count_valid;
    logic              count_ready;
    logic              overrun;
    logic              frame_err;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    temp_count_rx dut (
        .ref_clk     (ref_clk),
        .reset_12    (reset_12),
        .sr_in       (sr_in),
        .count_out   (count_out),
        .count_valid (count_valid),
        .count_ready (count_ready),
        .overrun     (overrun),
        .frame_err   (frame_err)
    );

    initial ref_clk = 1'b0;
    always #5 ref_clk = ~ref_clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge ref_clk);
        @(negedge ref_clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        sr_in = b;
        tick();
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0);
    endtask

    task automatic send_bits(input logic [DATA_W-1:0] v, input int n);
        for (int i = 0; i < n; i++) send_bit(v[i]);
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] v);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bits(v, DATA_W);
    endtask

    task automatic do_reset();
        reset_12    = 1'b1;
        sr_in       = 1'b0;
        count_ready = 1'b0;
        tick();
        reset_12 = 1'b0;
    endtask

    task automatic expect_result(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL %s: observed result %0h expected no pending entry", tag, count_out);
        end else begin
            e = exp_q.pop_front();
            check(tag, {12'h0, count_out}, e);
        end
    endtask

    task automatic consume(input string tag);
        count_ready = 1'b1;
        tick();
        count_ready = 1'b0;
        check(tag, {31'h0, count_valid}, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_12    = 1'b1;
        sr_in       = 1'b0;
        count_ready = 1'b0;
        @(negedge ref_clk);
        do_reset();
        check("rst_count_out", {12'h0, count_out}, 32'h0);
        check("rst_valid",     {31'h0, count_valid}, 32'h0);
        check("rst_overrun",   {31'h0, overrun}, 32'h0);
        check("rst_frame_err", {31'h0, frame_err}, 32'h0);

`ifdef TEMP_RX_AVG_EN
        gap(64); send_frame(20'd100); send_bit(1'b0);
        check("avg_f1_novalid", {31'h0, count_valid}, 32'h0);
        gap(64); send_frame(20'd101); send_bit(1'b0);
        check("avg_f2_novalid", {31'h0, count_valid}, 32'h0);
        gap(64); send_frame(20'd102); send_bit(1'b0);
        check("avg_f3_novalid", {31'h0, count_valid}, 32'h0);
        gap(64); send_frame(20'd104);
        exp_q.push_back(32'd101);
        check("avg_f4_latency", {31'h0, count_valid}, 32'h0);
        send_bit(1'b0);
        check("avg_f4_valid", {31'h0, count_valid}, 32'h1);
        expect_result("avg_mean");
        consume("avg_consume");
`else
        // Basic frame, latency, and hold while not ready.
        gap(64);
        send_frame(20'h5A5A3);
        exp_q.push_back(32'h5A5A3);
        check("t1_latency", {31'h0, count_valid}, 32'h0);
        send_bit(1'b0);
        check("t1_valid", {31'h0, count_valid}, 32'h1);
        expect_result("t1_count");
        gap(64);
        check("t1_hold_valid", {31'h0, count_valid}, 32'h1);
        check("t1_hold_count", {12'h0, count_out}, 32'h5A5A3);
        consume("t1_consume");

        // Too-short gap must not lock; a proper gap then does.
        do_reset();
        gap(10);
        send_frame(20'h12345);
        send_bit(1'b0);
        check("t2_short_gap", {31'h0, count_valid}, 32'h0);
        gap(64);
        send_frame(20'h00001);
        exp_q.push_back(32'h00001);
        send_bit(1'b0);
        check("t2_valid", {31'h0, count_valid}, 32'h1);
        expect_result("t2_count");
        consume("t2_consume");

        // Malformed marker pulses frame_err for one cycle, then recovery.
        gap(64);
        send_bit(1'b1);
        check("t3_err_before", {31'h0, frame_err}, 32'h0);
        send_bit(1'b0);
        check("t3_err_pulse", {31'h0, frame_err}, 32'h1);
        send_bit(1'b0);
        check("t3_err_clear", {31'h0, frame_err}, 32'h0);
        gap(64);
        send_frame(20'hFFFFF);
        exp_q.push_back(32'hFFFFF);
        send_bit(1'b0);
        check("t3_valid", {31'h0, count_valid}, 32'h1);
        expect_result("t3_count");
        consume("t3_consume");

        // Overrun: second frame dropped while first is unconsumed.
        do_reset();
        gap(64); send_frame(20'h00010);
        exp_q.push_back(32'h00010);
        send_bit(1'b0);
        expect_result("t4_first");
        gap(64); send_frame(20'h00020);
        send_bit(1'b0);
        check("t4_keep_old", {12'h0, count_out}, 32'h00010);
        check("t4_overrun", {31'h0, overrun}, 32'h1);
        check("t4_valid", {31'h0, count_valid}, 32'h1);

        // Accept on the completion edge: new result loads, no overrun.
        do_reset();
        check("t4b_overrun_rst", {31'h0, overrun}, 32'h0);
        gap(64); send_frame(20'h00010);
        exp_q.push_back(32'h00010);
        send_bit(1'b0);
        expect_result("t4b_first");
        gap(64); send_frame(20'h00020);
        exp_q.push_back(32'h00020);
        count_ready = 1'b1;
        send_bit(1'b0);
        count_ready = 1'b0;
        expect_result("t4b_second");
        check("t4b_valid", {31'h0, count_valid}, 32'h1);
        check("t4b_no_overrun", {31'h0, overrun}, 32'h0);

        // Reset at data bit 9 discards the partial frame and clears outputs.
        gap(64);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bits(20'h3C3C3, 9);
        reset_12 = 1'b1;
        sr_in    = 1'b1;
        tick();
        reset_12 = 1'b0;
        check("t5_count_out", {12'h0, count_out}, 32'h0);
        check("t5_valid",     {31'h0, count_valid}, 32'h0);
        check("t5_overrun",   {31'h0, overrun}, 32'h0);
        check("t5_frame_err", {31'h0, frame_err}, 32'h0);
        gap(64);
        send_frame(20'hABCDE);
        exp_q.push_back(32'hABCDE);
        send_bit(1'b0);
        check("t5_valid_after", {31'h0, count_valid}, 32'h1);
        expect_result("t5_count");
`endif

        check("scoreboard_empty", exp_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/temp_count_rx.md
# temp_count_rx

Receive-side deserializer for the temperature-sensor frequency counter's serial output. Samples the serial count stream on the shift reference clock, locks onto each frame's start marker, reassembles the 20-bit LSB-first count, and presents it on a valid/ready interface to the digital back-end. It sits directly downstream of the sensor's PISO shift stage and is clocked by that stage's exported reference clock.

## Interface
- `DATA_W`, 20: count width per frame.
- `MARK_CYCLES`, 2: consecutive sampled 1s forming the start marker.
- `MIN_GAP`, 64: consecutive sampled 0s required before a marker is accepted.
- `AVG_LOG2`, 2: log2 of frames averaged (used only with `TEMP_RX_AVG_EN`).
- `ref_clk` in 1: sole clock; the sensor's shift/reference clock, rising edge.
- `reset_12` in 1: synchronous, active-high reset.
- `sr_in` in 1: serial count stream from the sensor shift stage.
- `count_out` out `DATA_W`: last completed count (or average).
- `count_valid` out 1: `count_out` holds an unconsumed result.
- `count_ready` in 1: consumer accepts the result.
- `overrun` out 1: sticky; a result was dropped because the previous one was not consumed.
- `frame_err` out 1: one-cycle pulse on a malformed marker.

## Operation
- `sr_in` is sampled once per `ref_clk` rising edge; no other sampling is performed.
- FSM states: GAP, IDLE, MARK, DATA.
  - GAP: count consecutive 0s (saturating at `MIN_GAP`); any 1 clears the count. At count == `MIN_GAP`, go to IDLE.
  - IDLE: a sampled 1 goes to MARK with mark count = 1.
  - MARK: a 1 increments the mark count. When the mark count reaches `MARK_CYCLES`, go to DATA with bit index 0.
  - MARK, early 0: a 0 before the mark count reaches `MARK_CYCLES` pulses `frame_err` and returns to GAP with the zero count set to 1.
  - DATA: the sample is written into bit [bit index] of the shift register, so the first data sample is the LSB. After bit `DATA_W`-1, the frame is complete; go to GAP with the zero count cleared.
- 1s inside DATA are payload, never markers.
- Frame complete, no averaging:
  - If `count_valid`=0 or the accept occurs in the same cycle: load `count_out` and set `count_valid`=1.
  - Otherwise: keep the old result and set `overrun`=1.
- Accept: `count_valid` && `count_ready` clears `count_valid` on the next edge.
  - Simultaneous accept and completion: the new result is loaded, `count_valid` stays 1, and no overrun is flagged.
- `overrun` clears only on reset.

## Timing
- Reset values: `count_out`=0, `count_valid`=0, `overrun`=0, `frame_err`=0; FSM=GAP with all counters 0.
- Reset mid-frame discards the partial frame.
- With the default `MARK_CYCLES`=2, the 2 marker samples are followed by 20 data samples.
- Latency: `count_valid` rises on the edge after the sample of data bit `DATA_W`-1. That is 1 cycle after the last data bit, and 22 edges after the first marker sample.
- `frame_err` is high for exactly one cycle.
- Bit index and the GAP counter use the minimal widths `clog2(DATA_W)` and `clog2(MIN_GAP+1)`. The GAP counter saturates and never wraps.
- Nominal frame period is 4096 `ref_clk` cycles. Nothing in the block depends on this period.

## Configuration
- `TEMP_RX_AVG_EN` defined:
  - Completed frames are summed into a (`DATA_W`+`AVG_LOG2`)-bit accumulator.
  - After 2^`AVG_LOG2` frames, `count_out` = sum >> `AVG_LOG2` (truncated), and the result enters the valid/overrun logic above.
  - The accumulator then clears. Reset clears the accumulator and the frame tally.
- `TEMP_RX_AVG_EN` undefined: every frame is output directly, and no accumulator logic exists.

## Structure
- Package `temp_rx_pkg`:
  - FSM state encoding (GAP=0, IDLE=1, MARK=2, DATA=3).
  - Default constants `DATA_W`=20, `MARK_CYCLES`=2, `MIN_GAP`=64.
- One sub-module, `temp_rx_avg`: the accumulator and frame tally, instantiated only under `TEMP_RX_AVG_EN`.
- FSM, shift register and handshake stay in the top module.

## Test plan
- Reset, then 64 zeros, then 1,1, then 20'h5A5A3 LSB-first -> `count_valid`=1 and `count_out`=20'h5A5A3 one cycle after the last bit. Hold `count_ready`=0 -> the result stays.
- Only 10 zeros, then a frame -> no `count_valid`. A following 64 zeros plus frame 20'h00001 -> `count_out`=1.
- Marker 1,0 after a valid gap -> `frame_err` pulses once; the next full frame 20'hFFFFF decodes correctly.
- Two frames (20'h00010, then 20'h00020) with `count_ready`=0 throughout -> `count_out`=20'h00010 and `overrun`=1. Repeat with `count_ready` pulsed on the completion edge of the second frame -> `count_out`=20'h00020 and `overrun`=0.
- Assert `reset_12` at data bit 9 -> all outputs return to 0 next edge, and a subsequent full frame decodes correctly.
- With `TEMP_RX_AVG_EN` and `AVG_LOG2`=2, frames 100, 101, 102, 104 -> a single result, `count_out`=101 (407>>2); no `count_valid` after frames 1–3.
